// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch run-control sequencer.
//   stw_state_e : FSM state encoding, also driven on the state output
//   div_of      : system clocks per count tick (CLK_HZ / TICK_HZ)
//   presc_w     : prescaler width, clog2(DIV)
//   dbnc_w      : width of the debounce stability down-counter
//   lap_w       : width of the lap auto-release tick counter
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      LAP   = 2'b11
   } stw_state_e;

   function automatic int div_of(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

   function automatic int presc_w(input int div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

   // counter holds DEBOUNCE_CYC-1 down to 0
   function automatic int dbnc_w(input int cyc);
      return (cyc <= 2) ? 1 : $clog2(cyc);
   endfunction

   // counter holds LAP_TIMEOUT_TICKS down to 1
   function automatic int lap_w(input int n);
      return (n <= 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability down-counter and
// rising-edge press detector.
//   clk_in : system clock
//   rst_n  : asynchronous active-low reset
//   raw    : raw asynchronous button level
//   level  : debounced level, follows raw after DEBOUNCE_CYC equal samples
//   press  : one-cycle pulse on each rising edge of level
module btn_debounce
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CW = dbnc_w(DEBOUNCE_CYC);
   localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYC - 1);

   logic          sync_1;
   logic          sync_2;
   logic [CW-1:0] stab_cnt;
   logic          settle;

   // Reset value 0 is safe: sync_2 reads 0 on the first edge after reset,
   // so the counter is reloaded before any differing sample can arrive.
   assign settle = (sync_2 != level) && (stab_cnt == '0);

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         stab_cnt <= '0;
         level    <= 1'b0;
         press    <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
         press  <= settle && sync_2;
         if (sync_2 == level) begin
            stab_cnt <= RELOAD;
         end else if (settle) begin
            level    <= sync_2;
            stab_cnt <= RELOAD;
         end else begin
            stab_cnt <= stab_cnt - CW'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control sequencer: debounces start/stop, lap and clear,
// sequences the counter and display, and generates the count tick.
//   clk_in    : system clock
//   rst_n     : asynchronous active-low reset
//   btn_ss    : raw start/stop button
//   btn_lap   : raw lap button
//   btn_clr   : raw clear button
//   tick      : one-cycle pulse per count period while counting
//   cnt_en    : counter enable (RUN, LAP)
//   cnt_clr   : one-cycle counter clear pulse
//   disp_hold : display freeze (LAP)
//   state     : current FSM state
// Build option STW_LAP_TIMEOUT_EN: LAP releases back to RUN on its own after
// LAP_TIMEOUT_TICKS ticks.
//
// state | meaning
// IDLE  | stopped and cleared, waiting for start
// RUN   | counting, display live
// PAUSE | counting halted, prescaler phase kept
// LAP   | counting, display frozen
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ            = 100_000_000,
   parameter int TICK_HZ           = 100,
   parameter int DEBOUNCE_CYC      = 1_000_000,
   parameter int LAP_TIMEOUT_TICKS = 300
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       btn_ss,
   input  logic       btn_lap,
   input  logic       btn_clr,
   output logic       tick,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       disp_hold,
   output logic [1:0] state
);

   localparam int DIV = div_of(CLK_HZ, TICK_HZ);
   localparam int PW  = presc_w(DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   // Only the press events drive the sequencer; the debounced levels are
   // left for whoever needs them later.
   logic [2:0]    unused_levels;
   logic          ev_ss;
   logic          ev_lap;
   logic          ev_clr;

   stw_state_e    state_q;
   stw_state_e    state_d;
   logic          clr_acc;
   logic          cnt_clr_q;
   logic [PW-1:0] presc_q;
   logic          lap_timeout;

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dbnc_ss (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .raw    (btn_ss),
      .level  (unused_levels[0]),
      .press  (ev_ss)
   );

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dbnc_lap (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .raw    (btn_lap),
      .level  (unused_levels[1]),
      .press  (ev_lap)
   );

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dbnc_clr (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .raw    (btn_clr),
      .level  (unused_levels[2]),
      .press  (ev_clr)
   );

   assign state     = state_q;
   assign cnt_en    = (state_q == RUN) || (state_q == LAP);
   assign disp_hold = (state_q == LAP);
   assign cnt_clr   = cnt_clr_q;
   assign tick      = cnt_en && (presc_q == PRESC_LAST);

   // Events a state ignores do not block lower-priority ones.
   always_comb begin
      state_d = state_q;
      clr_acc = 1'b0;
      case (state_q)
         IDLE: begin
            if (ev_clr) begin
               clr_acc = 1'b1;
            end else if (ev_ss) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (ev_ss) begin
               state_d = PAUSE;
            end else if (ev_lap) begin
               state_d = LAP;
            end
         end
         LAP: begin
            if (ev_ss) begin
               state_d = PAUSE;
            end else if (ev_lap || lap_timeout) begin
               state_d = RUN;
            end
         end
         PAUSE: begin
            if (ev_clr) begin
               state_d = IDLE;
               clr_acc = 1'b1;
            end else if (ev_ss) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_clr_q <= 1'b0;
         presc_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_clr_q <= clr_acc;
         if (clr_acc) begin
            presc_q <= '0;
         end else if (cnt_en) begin
            presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
         end
      end
   end

`ifdef STW_LAP_TIMEOUT_EN
   localparam int LW = lap_w(LAP_TIMEOUT_TICKS);
   localparam logic [LW-1:0] LAP_RELOAD = LW'(LAP_TIMEOUT_TICKS);

   logic [LW-1:0] lap_cnt;

   // Reloaded whenever not in LAP, so every entry starts a fresh timeout.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         lap_cnt <= '0;
      end else if (state_q != LAP) begin
         lap_cnt <= LAP_RELOAD;
      end else if (tick && (lap_cnt != '0)) begin
         lap_cnt <= lap_cnt - LW'(1);
      end
   end

   assign lap_timeout = (state_q == LAP) && tick && (lap_cnt == LW'(1));
`else
   localparam int unused_lap_timeout_ticks = LAP_TIMEOUT_TICKS;
   assign lap_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

   localparam int CLK_HZ  = 1000;
   localparam int TICK_HZ = 100;
   localparam int DBC     = 4;
   localparam int LAPN    = 3;
   localparam int DIV     = CLK_HZ / TICK_HZ;

   logic       clk_in  = 1'b0;
   logic       rst_n   = 1'b0;
   logic       btn_ss  = 1'b0;
   logic       btn_lap = 1'b0;
   logic       btn_clr = 1'b0;
   logic       tick;
   logic       cnt_en;
   logic       cnt_clr;
   logic       disp_hold;
   logic [1:0] state;

   stopwatch_ctrl #(
      .CLK_HZ            (CLK_HZ),
      .TICK_HZ           (TICK_HZ),
      .DEBOUNCE_CYC      (DBC),
      .LAP_TIMEOUT_TICKS (LAPN)
   ) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .btn_ss    (btn_ss),
      .btn_lap   (btn_lap),
      .btn_clr   (btn_clr),
      .tick      (tick),
      .cnt_en    (cnt_en),
      .cnt_clr   (cnt_clr),
      .disp_hold (disp_hold),
      .state     (state)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // button index: 0 = ss, 1 = lap, 2 = clr
   // state codes: 0 idle, 1 run, 2 pause, 3 lap
   int m_p1 [3];
   int m_p2 [3];
   int m_hist [3][$];
   int m_lvl [3];
   int m_ev [3];
   int m_state;
   int m_en_cycles;     // enabled cycles since the last clear
   int m_lap_ticks;     // ticks seen during the current LAP visit
   int m_cnt_clr;

   function automatic int en_of(input int s);
      return (s == 1 || s == 3) ? 1 : 0;
   endfunction

   function automatic int m_tick();
      return (en_of(m_state) == 1 && (m_en_cycles % DIV) == DIV - 1) ? 1 : 0;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 3; b++) begin
         m_p1[b] = 0;
         m_p2[b] = 0;
         m_hist[b].delete();
         m_lvl[b] = 0;
         m_ev[b]  = 0;
      end
      m_state     = 0;
      m_en_cycles = 0;
      m_lap_ticks = 0;
      m_cnt_clr   = 0;
   endtask

   task automatic model_step();
      int raw [3];
      int ns;
      int clr_acc;
      int tk;
      int to;
      raw[0] = int'(btn_ss);
      raw[1] = int'(btn_lap);
      raw[2] = int'(btn_clr);
      ns = m_state;
      clr_acc = 0;
      tk = m_tick();
      to = 0;
`ifdef STW_LAP_TIMEOUT_EN
      if (m_state == 3 && tk == 1 && m_lap_ticks + 1 == LAPN) to = 1;
`endif
      case (m_state)
         0: if (m_ev[2] == 1) clr_acc = 1; else if (m_ev[0] == 1) ns = 1;
         1: if (m_ev[0] == 1) ns = 2; else if (m_ev[1] == 1) ns = 3;
         3: if (m_ev[0] == 1) ns = 2; else if (m_ev[1] == 1 || to == 1) ns = 1;
         default: if (m_ev[2] == 1) begin ns = 0; clr_acc = 1; end
                  else if (m_ev[0] == 1) ns = 1;
      endcase
      if (clr_acc == 1) m_en_cycles = 0;
      else if (en_of(m_state) == 1) m_en_cycles++;
      if (m_state == 3 && tk == 1) m_lap_ticks++;
      if (m_state != 3 || ns != 3) m_lap_ticks = 0;
      m_state   = ns;
      m_cnt_clr = clr_acc;
      for (int b = 0; b < 3; b++) begin
         int syn;
         int nl;
         int all_diff;
         syn = m_p2[b];
         m_p2[b] = m_p1[b];
         m_p1[b] = raw[b];
         m_hist[b].push_back(syn);
         if (m_hist[b].size() > DBC) void'(m_hist[b].pop_front());
         nl = m_lvl[b];
         all_diff = (m_hist[b].size() == DBC) ? 1 : 0;
         foreach (m_hist[b][k]) if (m_hist[b][k] == m_lvl[b]) all_diff = 0;
         if (all_diff == 1) nl = 1 - m_lvl[b];
         m_ev[b]  = (nl == 1 && m_lvl[b] == 0) ? 1 : 0;
         m_lvl[b] = nl;
      end
   endtask

   task automatic compare_all();
      chk("state",     32'(state),     32'(m_state));
      chk("cnt_en",    32'(cnt_en),    32'(en_of(m_state)));
      chk("disp_hold", 32'(disp_hold), 32'(m_state == 3));
      chk("cnt_clr",   32'(cnt_clr),   32'(m_cnt_clr));
      chk("tick",      32'(tick),      32'(m_tick()));
   endtask

   task automatic step();
      @(posedge clk_in);
      if (rst_n) model_step();
      #1;
      compare_all();
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: btn_ss  = v;
         1: btn_lap = v;
         default: btn_clr = v;
      endcase
   endtask

   task automatic press(input int b, input int hold, input int gap);
      set_btn(b, 1'b1);
      repeat (hold) step();
      set_btn(b, 1'b0);
      repeat (gap) step();
   endtask

   task automatic count_while(input int cycles, output int n_tick, output int n_clr);
      n_tick = 0;
      n_clr  = 0;
      repeat (cycles) begin
         step();
         if (tick === 1'b1) n_tick++;
         if (cnt_clr === 1'b1) n_clr++;
      end
   endtask

   int lat;
   int nt;
   int nc;
   int hold_left [3];

   initial begin
      model_reset();
      #1;
      chk("rst_state",   32'(state), 0);
      chk("rst_cnt_en",  32'(cnt_en), 0);
      chk("rst_tick",    32'(tick), 0);
      chk("rst_cnt_clr", 32'(cnt_clr), 0);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (3) step();

      // 1: single held press, latency and first tick position
      btn_ss = 1'b1;
      lat = 0;
      while (state !== 2'b01 && lat < 20) begin
         step();
         lat++;
      end
      chk("ss_latency", 32'(lat), 32'(2 + DBC + 1));
      nt = 0;
      while (tick !== 1'b1 && nt < 30) begin
         step();
         nt++;
      end
      chk("first_tick_cycle", 32'(nt + 1), 32'(DIV));
      repeat (4) step();
      btn_ss = 1'b0;
      count_while(30, nt, nc);
      chk("run_ticks", 32'(nt), 3);

      // 2: short glitch ignored, bounce train then stable high accepted
      press(0, 3, 10);
      chk("glitch_state", 32'(state), 1);
      for (int i = 0; i < 5; i++) begin
         btn_ss = (i % 2 == 0) ? 1'b1 : 1'b0;
         step();
      end
      repeat (12) step();
      btn_ss = 1'b0;
      repeat (8) step();
      chk("bounce_state", 32'(state), 2);

      // 3: resume, pause mid-period, no ticks while paused
      press(0, 8, 0);
      repeat (17) step();
      press(0, 8, 0);
      count_while(50, nt, nc);
      chk("pause_ticks", 32'(nt), 0);
      press(0, 8, 20);

      // 4: clear only honoured when stopped
      press(0, 8, 8);
      count_while(0, nt, nc);
      btn_clr = 1'b1;
      count_while(10, nt, nc);
      btn_clr = 1'b0;
      chk("clr_pulses", 32'(nc), 1);
      chk("clr_state", 32'(state), 0);
      press(0, 8, 8);
      btn_clr = 1'b1;
      count_while(10, nt, nc);
      btn_clr = 1'b0;
      chk("clr_in_run", 32'(nc), 0);
      repeat (5) step();

      // 5: simultaneous presses in RUN, then lap
      btn_ss = 1'b1; btn_lap = 1'b1; btn_clr = 1'b1;
      repeat (8) step();
      btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
      repeat (8) step();
      chk("simul_state", 32'(state), 2);
      press(0, 8, 8);
      press(1, 8, 4);
      chk("lap_state", 32'(state), 3);
      chk("lap_hold", 32'(disp_hold), 1);
      count_while(40, nt, nc);
      chk("lap_ticks_nonzero", 32'(nt > 0), 1);
      if (state !== 2'b11) press(1, 8, 2);

      // 6: asynchronous reset while in LAP
      rst_n = 1'b0;
      #1;
      chk("arst_state",  32'(state), 0);
      chk("arst_cnt_en", 32'(cnt_en), 0);
      chk("arst_hold",   32'(disp_hold), 0);
      chk("arst_tick",   32'(tick), 0);
      model_reset();
      repeat (2) step();
      rst_n = 1'b1;
      count_while(30, nt, nc);
      chk("post_rst_ticks", 32'(nt), 0);

      // randomized button activity against the model
      for (int b = 0; b < 3; b++) hold_left[b] = 0;
      repeat (4000) begin
         for (int b = 0; b < 3; b++) begin
            if (hold_left[b] == 0) begin
               set_btn(b, ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
               hold_left[b] = int'($urandom_range(1, 14));
            end else begin
               hold_left[b]--;
            end
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run-control sequencer for the stopwatch counter and display datapath. It debounces three raw push-buttons (start/stop, lap, clear) and runs a 4-state FSM. It drives the counter enable/clear, generates the count tick from the system clock, and freezes the display during lap. It sits between the board buttons and the stopwatch BCD counter / 7-segment scan logic.

Parameters:
CLK_HZ, 100_000_000, system clock frequency.
TICK_HZ, 100, count tick rate (centiseconds). DIV = CLK_HZ/TICK_HZ, an integer ≥ 2.
DEBOUNCE_CYC, 1_000_000, number of stable cycles required to accept a button level (10 ms).
LAP_TIMEOUT_TICKS, 300, auto lap release in ticks. Used only with STW_LAP_TIMEOUT_EN.

Ports:
clk_in  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
btn_ss  input  1  raw start/stop button, asynchronous, active-high
btn_lap  input  1  raw lap button, asynchronous, active-high
btn_clr  input  1  raw clear button, asynchronous, active-high
tick  output  1  one-cycle pulse per count period while counting
cnt_en  output  1  counter enable; high in RUN and LAP
cnt_clr  output  1  one-cycle counter clear pulse
disp_hold  output  1  display latch freeze; high in LAP
state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, LAP=11

Behaviour:
- Reset: rst_n low clears all flops asynchronously. Outputs then read: state=IDLE, tick=0, cnt_en=0, cnt_clr=0, disp_hold=0; prescaler=0; debounced levels=0. Reset mid-run aborts immediately; no clear pulse is issued.
- Button path, per button:
  - 2-flop synchronizer, then stability counter; the debounced level updates after DEBOUNCE_CYC consecutive equal synchronized samples.
  - Press event = rising edge of the debounced level, exactly 1 cycle wide.
  - Release generates no event. Holding a button produces one event only.
  - Latency from a raw edge to the event is 2 + DEBOUNCE_CYC + 1 cycles (±1).
- Simultaneous events in the same cycle: priority is clr > ss > lap. Lower-priority events are dropped, not queued.
- FSM, registered; outputs are decoded from the registered state:
  - IDLE: ss -> RUN. clr -> IDLE with a cnt_clr pulse. lap is ignored.
  - RUN: ss -> PAUSE. lap -> LAP. clr is ignored.
  - LAP: lap -> RUN. ss -> PAUSE; disp_hold drops in that same transition. clr is ignored.
  - PAUSE: ss -> RUN. clr -> IDLE with a cnt_clr pulse. lap is ignored.
- cnt_clr is asserted in the cycle after the clr event is accepted, for 1 cycle. In that same cycle the prescaler is zeroed.
- Prescaler:
  - Counts 0..DIV-1 only while cnt_en=1.
  - tick is high in the cycle the count equals DIV-1; the count then wraps to 0.
  - In PAUSE the count holds its value; resume continues from it, so no partial period is lost.
  - First tick after IDLE->RUN arrives DIV cycles after cnt_en rises.
- Counting continues through LAP; only the display is frozen.

Optional Feature:
STW_LAP_TIMEOUT_EN:
- Defined: a tick counter runs while in LAP. After LAP_TIMEOUT_TICKS ticks, the FSM returns to RUN and disp_hold drops. Any LAP exit or re-entry resets this counter.
- Undefined: LAP persists until a lap or ss event, and no timeout logic is synthesized.

Decomposition:
- Package stopwatch_pkg holds:
  - state encoding constants IDLE/RUN/PAUSE/LAP;
  - the DIV derivation and prescaler width as clog2(DIV);
  - the debounce counter width function.
- Sub-module btn_debounce (parameter DEBOUNCE_CYC; ports clk_in, rst_n, raw, level, press). It is instantiated 3 times.
- FSM and prescaler stay in stopwatch_ctrl.

Test Plan:
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (DIV=10), DEBOUNCE_CYC=4, LAP_TIMEOUT_TICKS=3; 10 ns clock.
1. Reset, then one ss press held 20 cycles -> exactly one event ~7 cycles after the raw edge; state=01, cnt_en=1; tick every 10 cycles with the first 10 cycles after cnt_en.
2. A 3-cycle raw glitch on btn_ss, then a 5-cycle bounce train ending high -> no event from the glitch; one event after the level is stable for 4 cycles.
3. RUN, ss after 25 cycles (prescaler=5), wait 50 cycles, ss again -> no ticks during PAUSE; the next tick comes 5 cycles after resume.
4. PAUSE, clr -> cnt_clr=1 for 1 cycle; state=00; prescaler=0. Then clr in RUN -> ignored, no cnt_clr.
5. RUN, ss+lap+clr raw edges in the same cycle -> clr ignored in RUN, ss wins; state=10; disp_hold stays 0. Then lap in RUN -> state=11, disp_hold=1, tick continues. With STW_LAP_TIMEOUT_EN: back to 01 after 3 ticks.
6. rst_n low for 2 cycles while in LAP -> all outputs 0 immediately (asynchronous); state=00 after release; no tick until the next ss event.
